// File: rtl/request_unit_pkg.sv
// rtl/request_unit_pkg.sv - shared types and constants for the request unit
// Purpose: FSM state and transaction-source enums, default RAM address width,
//          and the data word returned on a watchdog timeout.
package request_unit_pkg;

  localparam int          RAM_ADDR_W_DEF = 12;
  localparam logic [31:0] BAD_DATA       = 32'hBAD1BAD1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } src_e;

endpackage

// File: rtl/request_unit_busy_fall.sv
// rtl/request_unit_busy_fall.sv - RAM busy falling-edge detector
// Purpose: registers the previous busy level and flags the 1 -> 0 transition.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   busy_i in  RAM busy
//   fall_o out high in the cycle busy_i is low after being high
module busy_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  output logic fall_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = busy_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign fall_o = prev_q & ~busy_i;

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - CPU-side initiator for the single-port word RAM
// Purpose: arbitrates fetch and data load/store requests (data first), runs one
//          RAM transaction at a time and returns one-cycle ready pulses.
// Optional feature macro: REQUEST_UNIT_TIMEOUT_EN (watchdog, err_o pulse).
// Ports:
//   clk, RST                      clock, asynchronous active-high reset
//   i_req/i_adr -> i_dat/i_ready  instruction fetch request and completion
//   d_read/d_write/d_adr/d_wdat/d_sel -> d_rdat/d_ready  data request and completion
//   read_o/write_o/adr_o/dat_o/sel_o  RAM strobes, word address, write data, byte select
//   ram_dat_i/ram_busy_i          RAM read data and busy handshake
//   err_o                         watchdog timeout pulse (0 when feature disabled)
module request_unit
  import request_unit_pkg::*;
#(
  parameter int RAM_ADDR_W     = RAM_ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  i_req,
  input  logic [31:0]           i_adr,
  output logic [31:0]           i_dat,
  output logic                  i_ready,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [31:0]           d_adr,
  input  logic [31:0]           d_wdat,
  input  logic [3:0]            d_sel,
  output logic [31:0]           d_rdat,
  output logic                  d_ready,
  output logic                  read_o,
  output logic                  write_o,
  output logic [RAM_ADDR_W-1:0] adr_o,
  output logic [31:0]           dat_o,
  output logic [3:0]            sel_o,
  input  logic [31:0]           ram_dat_i,
  input  logic                  ram_busy_i,
  output logic                  err_o
);

  state_e                state_q, state_d;
  src_e                  src_q, src_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [RAM_ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           i_dat_q, i_dat_d;
  logic [31:0]           d_rdat_q, d_rdat_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic                  err_q, err_d;

  logic                  busy_fall;
  logic                  finish;
  logic                  capture;
  logic [31:0]           cap_dat;

  // Only the word-address bits reach the RAM; the rest are deliberately ignored.
  logic unused_adr;
  assign unused_adr = ^{i_adr[31:RAM_ADDR_W+2], i_adr[1:0],
                        d_adr[31:RAM_ADDR_W+2], d_adr[1:0]};

`ifdef REQUEST_UNIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  busy_fall_det u_busy_fall (
    .clk    (clk),
    .rst    (RST),
    .busy_i (ram_busy_i),
    .fall_o (busy_fall)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    read_d    = read_q;
    write_d   = write_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    i_dat_d   = i_dat_q;
    d_rdat_d  = d_rdat_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    err_d     = 1'b0;
    finish    = 1'b0;
    capture   = 1'b0;
    cap_dat   = ram_dat_i;
`ifdef REQUEST_UNIT_TIMEOUT_EN
    cnt_d     = '0;
`endif

    case (state_q)
      IDLE: begin
        // Data stage has priority; read+write together is served as a write.
        if (d_write) begin
          write_d = 1'b1;
          adr_d   = d_adr[RAM_ADDR_W+1:2];
          dat_d   = d_wdat;
          sel_d   = d_sel;
          src_d   = STORE;
          state_d = REQ;
        end else if (d_read) begin
          read_d  = 1'b1;
          adr_d   = d_adr[RAM_ADDR_W+1:2];
          dat_d   = 32'h0;
          sel_d   = d_sel;
          src_d   = LOAD;
          state_d = REQ;
        end else if (i_req) begin
          read_d  = 1'b1;
          adr_d   = i_adr[RAM_ADDR_W+1:2];
          dat_d   = 32'h0;
          sel_d   = 4'hF;
          src_d   = FETCH;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ram_busy_i) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (busy_fall) begin
          finish  = 1'b1;
          capture = (src_q != STORE);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef REQUEST_UNIT_TIMEOUT_EN
    // Counter only advances while parked in REQ/WAIT; any state change restarts it.
    if ((state_q == REQ || state_q == WAIT) && !finish && state_d == state_q) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        finish  = 1'b1;
        capture = 1'b1;
        cap_dat = BAD_DATA;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
`endif

    // Completion: the ready pulse and captured data appear together in DONE.
    if (finish) begin
      read_d    = 1'b0;
      write_d   = 1'b0;
      adr_d     = '0;
      dat_d     = 32'h0;
      sel_d     = 4'h0;
      state_d   = DONE;
      i_ready_d = (src_q == FETCH);
      d_ready_d = (src_q != FETCH);
      if (capture) begin
        if (src_q == FETCH) begin
          i_dat_d = cap_dat;
        end else begin
          d_rdat_d = cap_dat;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      src_q     <= FETCH;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      adr_q     <= '0;
      dat_q     <= 32'h0;
      sel_q     <= 4'h0;
      i_dat_q   <= 32'h0;
      d_rdat_q  <= 32'h0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef REQUEST_UNIT_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      read_q    <= read_d;
      write_q   <= write_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      i_dat_q   <= i_dat_d;
      d_rdat_q  <= d_rdat_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      err_q     <= err_d;
`ifdef REQUEST_UNIT_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign i_dat   = i_dat_q;
  assign i_ready = i_ready_q;
  assign d_rdat  = d_rdat_q;
  assign d_ready = d_ready_q;
  assign read_o  = read_q;
  assign write_o = write_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;
  assign sel_o   = sel_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - self-checking bench for request_unit
module tb_request_unit;

  localparam int K_FETCH = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BOTH  = 3;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_adr = 32'h0;
  logic [31:0] i_dat;
  logic        i_ready;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_adr = 32'h0;
  logic [31:0] d_wdat = 32'h0;
  logic [3:0]  d_sel = 4'h0;
  logic [31:0] d_rdat;
  logic        d_ready;
  logic        read_o;
  logic        write_o;
  logic [11:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] ram_dat = 32'h0;
  logic        ram_busy = 1'b0;
  logic        err_o;

  always #5 clk = ~clk;

  request_unit #(.RAM_ADDR_W(12), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .RST(RST),
    .i_req(i_req), .i_adr(i_adr), .i_dat(i_dat), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_adr(d_adr), .d_wdat(d_wdat),
    .d_sel(d_sel), .d_rdat(d_rdat), .d_ready(d_ready),
    .read_o(read_o), .write_o(write_o), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .ram_dat_i(ram_dat), .ram_busy_i(ram_busy), .err_o(err_o)
  );

  // RAM model: accepts a strobe when idle, busy for 3 cycles, data valid at busy fall.
  logic [31:0] mem [0:4095];
  int          bcnt = 0;
  bit          stuck = 1'b0;

  always @(posedge clk) begin
    if (stuck) begin
      ram_busy <= 1'b1;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) ram_busy <= 1'b0;
    end else if (read_o || write_o) begin
      ram_busy <= 1'b1;
      bcnt     <= 3;
      ram_dat  <= mem[adr_o];
      if (write_o) begin
        for (int b = 0; b < 4; b++)
          if (sel_o[b]) mem[adr_o][b*8 +: 8] <= dat_o[b*8 +: 8];
      end
    end else if (ram_busy) begin
      ram_busy <= 1'b0;
    end
  end

  typedef struct {
    int          kind;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [11:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    bit          fetch;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_ready: i_ready=%0b d_ready=%0b expected no ready at %0t",
               i_ready, d_ready, $time);
    end else begin
      e = sb.pop_front();
      if (e.fetch) begin
        chk("fetch_ready", {i_ready, d_ready}, 32'h2);
        chk("i_dat", i_dat, e.data);
      end else begin
        chk("data_ready", {i_ready, d_ready}, 32'h1);
        chk("d_rdat", d_rdat, e.data);
      end
    end
  endtask

  task automatic drop_all();
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    bit is_wr;
    is_wr = (v.kind == K_STORE) || (v.kind == K_BOTH);
    @(negedge clk);
    case (v.kind)
      K_FETCH: begin i_req = 1'b1; i_adr = v.adr; end
      K_LOAD:  begin d_read = 1'b1; end
      K_STORE: begin d_write = 1'b1; end
      default: begin d_read = 1'b1; d_write = 1'b1; end
    endcase
    if (v.kind != K_FETCH) begin
      d_adr = v.adr; d_wdat = v.wdat; d_sel = v.sel;
    end
    sb.push_back('{v.kind == K_FETCH, v.exp_data});
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("read_strobe", read_o, !is_wr);
        chk("write_strobe", write_o, is_wr);
        chk("adr_o", adr_o, v.exp_adr);
        chk("sel_o", sel_o, v.exp_sel);
        chk("dat_o", dat_o, is_wr ? v.wdat : 32'h0);
      end
      if (c == 3 || c == 5) begin
        chk("strobe_off", read_o | write_o, 0);
        chk("adr_stable", adr_o, v.exp_adr);
      end
      if (i_ready || d_ready) begin
        got = 1'b1;
        chk("latency", c, 6);
        chk("adr_clear", adr_o, 0);
        chk("sel_clear", sel_o, 0);
        chk("err_quiet", err_o, 0);
        sb_check();
        drop_all();
      end
    end
    if (!got) begin
      chk("ready_timeout", 0, 1);
      drop_all();
      sb.delete();
    end
  endtask

  initial begin
    int td, ti;
    for (int k = 0; k < 4096; k++) mem[k] = 32'h0;
    mem[4] = 32'h0051_3093;
    mem[9] = 32'hAABB_CCDD;

    vecs[0] = '{K_FETCH, 32'h0000_0010, 32'h0,         4'h0, 12'h004, 4'hF, 32'h0051_3093};
    vecs[1] = '{K_STORE, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 12'h008, 4'hF, 32'h0};
    vecs[2] = '{K_LOAD,  32'h0000_0020, 32'h0,         4'hF, 12'h008, 4'hF, 32'hDEAD_BEEF};
    vecs[3] = '{K_STORE, 32'h0000_0024, 32'h1122_3344, 4'h5, 12'h009, 4'h5, 32'hDEAD_BEEF};
    vecs[4] = '{K_LOAD,  32'h0000_0024, 32'h0,         4'hF, 12'h009, 4'hF, 32'hAA22_CC44};
    vecs[5] = '{K_FETCH, 32'hFFFF_C010, 32'h0,         4'h0, 12'h004, 4'hF, 32'h0051_3093};
    vecs[6] = '{K_LOAD,  32'h0000_0023, 32'h0,         4'h3, 12'h008, 4'h3, 32'hDEAD_BEEF};
    vecs[7] = '{K_BOTH,  32'h0000_0028, 32'h0BAD_F00D, 4'hF, 12'h00A, 4'hF, 32'hDEAD_BEEF};
    vecs[8] = '{K_LOAD,  32'h0000_0028, 32'h0,         4'hF, 12'h00A, 4'hF, 32'h0BAD_F00D};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_strobes", {read_o, write_o, i_ready, d_ready, err_o}, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_dat_sel", {dat_o[27:0], sel_o}, 0);
    chk("rst_i_dat", i_dat, 0);
    chk("rst_d_rdat", d_rdat, 0);
    RST = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Arbitration: load and fetch in the same cycle, data first
    @(negedge clk);
    i_req = 1'b1; i_adr = 32'h10;
    d_read = 1'b1; d_adr = 32'h20; d_sel = 4'hF;
    sb.push_back('{1'b0, 32'hDEAD_BEEF});
    sb.push_back('{1'b1, 32'h0051_3093});
    td = -1; ti = -1;
    for (int c = 1; c <= 40 && ti < 0; c++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        if (d_ready) begin td = c; d_read = 1'b0; end
        if (i_ready) begin ti = c; i_req = 1'b0; end
        sb_check();
      end
    end
    chk("arb_data_latency", td, 6);
    chk("arb_fetch_gap", (ti >= 0) && (ti - td >= 7), 1);
    drop_all();
    sb.delete();

    // Reset in the middle of a load: outputs clear at once, no ready afterwards
    @(negedge clk);
    d_read = 1'b1; d_adr = 32'h20; d_sel = 4'hF;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    #1;
    chk("midrst_strobes", {read_o, write_o, i_ready, d_ready}, 0);
    chk("midrst_adr", adr_o, 0);
    chk("midrst_sel", sel_o, 0);
    chk("midrst_d_rdat", d_rdat, 0);
    d_read = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (i_ready || d_ready) sb_check();
    end
    run_vec('{K_LOAD, 32'h20, 32'h0, 4'hF, 12'h008, 4'hF, 32'hDEAD_BEEF});

`ifdef REQUEST_UNIT_TIMEOUT_EN
    begin
      int te;
      stuck = 1'b1;
      repeat (3) @(negedge clk);
      d_read = 1'b1; d_adr = 32'h20; d_sel = 4'hF;
      sb.push_back('{1'b0, 32'hBAD1_BAD1});
      te = -1;
      for (int c = 1; c <= 40 && te < 0; c++) begin
        @(negedge clk);
        if (err_o) te = c;
        if (i_ready || d_ready) begin
          sb_check();
          d_read = 1'b0;
        end
      end
      chk("timeout_err_cycle", te, 10);
      d_read = 1'b0;
      @(negedge clk);
      chk("timeout_err_single", err_o, 0);
      chk("timeout_idle", {read_o, write_o, adr_o}, 0);
      stuck = 1'b0;
      sb.delete();
      repeat (3) @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
